core_op_driver: RTL and testbench

- Initiator for the standard crypto-core slave interface: data_in/add/control in, data_out/end_op out.
- Takes a start command plus a stream of N_IN 64-bit input words from the host side.
- Loads those words into the core, starts it, and waits for end_op under a timeout.
- Then reads N_OUT result words back and presents them as an output stream; sits between the host register/stream bridge and any core.

---
 rtl/core_op_driver.sv | 163 ++++++++++++++++
 tb/tb_core_op_driver.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_op_driver.sv
// Drives a crypto core through LOAD / START / WAIT / READ cycles,
// bridging a host input stream to a result stream.
module core_op_driver #(
   parameter int N_IN    = 4,
   parameter int N_OUT   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [27:0] i_mode,
   input  logic        i_abort,
   input  logic [63:0] i_s_data,
   input  logic        i_s_valid,
   output logic        o_s_ready,
   output logic [63:0] o_m_data,
   output logic        o_m_valid,
   output logic        o_m_last,
   input  logic        i_m_ready,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [63:0] o_core_data_in,
   output logic [63:0] o_core_add,
   output logic [31:0] o_core_control,
   input  logic [63:0] i_core_data_out,
   input  logic        i_core_end_op
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [3:0] OP_IDLE  = 4'd0;
   localparam logic [3:0] OP_LOAD  = 4'd1;
   localparam logic [3:0] OP_START = 4'd2;
   localparam logic [3:0] OP_READ  = 4'd3;
   localparam logic [7:0] IN_LAST  = 8'(N_IN - 1);
   localparam logic [7:0] OUT_LAST = 8'(N_OUT - 1);
   localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT,
      S_RD_REQ, S_RD_CAP, S_RD_OUT, S_DONE
   } state_t;

   state_t          r_state;
   logic [7:0]      r_k;
   logic [CW-1:0]   r_cnt;
   logic [27:0]     r_mode;
   logic            w_s_hs;
   logic            w_m_hs;
   logic [CW-1:0]   w_cnt_nx;

   assign w_s_hs   = i_s_valid & o_s_ready;
   assign w_m_hs   = o_m_valid & i_m_ready;
   assign w_cnt_nx = r_cnt + CW'(1);

   // Every output is set on the edge leaving the state that owns it.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state        <= S_IDLE;
         r_k            <= '0;
         r_cnt          <= '0;
         r_mode         <= '0;
         o_s_ready      <= 1'b0;
         o_m_data       <= '0;
         o_m_valid      <= 1'b0;
         o_m_last       <= 1'b0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_error        <= 1'b0;
         o_core_data_in <= '0;
         o_core_add     <= '0;
         o_core_control <= '0;
      end else begin
         o_core_control <= {r_mode, OP_IDLE};
         o_done         <= 1'b0;
         if (i_abort) begin
            r_state   <= S_IDLE;
            o_s_ready <= 1'b0;
            o_m_valid <= 1'b0;
            o_m_last  <= 1'b0;
            o_busy    <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (i_start) begin
                     r_mode         <= i_mode;
                     o_core_control <= {i_mode, OP_IDLE};
                     o_error        <= 1'b0;
                     r_k            <= '0;
                     o_s_ready      <= 1'b1;
                     o_busy         <= 1'b1;
                     r_state        <= S_LOAD;
                  end
               end
               S_LOAD: begin
                  if (w_s_hs) begin
                     o_core_control <= {r_mode, OP_LOAD};
                     o_core_add     <= {56'd0, r_k};
                     o_core_data_in <= i_s_data;
                     if (r_k == IN_LAST) begin
                        o_s_ready <= 1'b0;
                        r_k       <= '0;
                        r_state   <= S_START;
                     end else begin
                        r_k <= r_k + 8'd1;
                     end
                  end
               end
               S_START: begin
                  o_core_control <= {r_mode, OP_START};
                  o_core_add     <= '0;
                  r_cnt          <= '0;
                  r_state        <= S_WAIT;
               end
               S_WAIT: begin
                  // end_op wins over a timeout landing in the same cycle
                  if (i_core_end_op) begin
                     r_state <= S_RD_REQ;
                  end else begin
                     r_cnt <= w_cnt_nx;
                     if (w_cnt_nx == TO_MAX) begin
                        o_error <= 1'b1;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end
               end
               S_RD_REQ: begin
                  o_core_control <= {r_mode, OP_READ};
                  o_core_add     <= {56'd0, r_k};
                  r_state        <= S_RD_CAP;
               end
               S_RD_CAP: begin
                  o_m_data  <= i_core_data_out;
                  o_m_valid <= 1'b1;
                  o_m_last  <= (r_k == OUT_LAST);
                  r_state   <= S_RD_OUT;
               end
               S_RD_OUT: begin
                  if (w_m_hs) begin
                     o_m_valid <= 1'b0;
                     o_m_last  <= 1'b0;
                     if (r_k == OUT_LAST) begin
                        r_k     <= '0;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_k     <= r_k + 8'd1;
                        r_state <= S_RD_REQ;
                     end
                  end
               end
               S_DONE: begin
                  o_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_core_op_driver.sv
// Directed scoreboard bench for core_op_driver with a tiny core model.
module tb_core_op_driver;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [27:0] mode;
   logic        abort;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic        error;
   logic [63:0] core_din;
   logic [63:0] core_add;
   logic [31:0] core_ctl;
   logic [63:0] core_dout;
   logic        core_end;
   logic        core_allf;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int res_seen = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [63:0] add;
      logic [63:0] data;
      logic        chk_data;
      logic [27:0] md;
   } op_t;

   op_t          exp_ops[$];
   logic [64:0]  exp_res[$];
   logic [63:0]  words[4];

   core_op_driver #(.N_IN(4), .N_OUT(4), .TIMEOUT(8)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_mode(mode),
      .i_abort(abort), .i_s_data(s_data), .i_s_valid(s_valid),
      .o_s_ready(s_ready), .o_m_data(m_data), .o_m_valid(m_valid),
      .o_m_last(m_last), .i_m_ready(m_ready), .o_busy(busy),
      .o_done(done), .o_error(error), .o_core_data_in(core_din),
      .o_core_add(core_add), .o_core_control(core_ctl),
      .i_core_data_out(core_dout), .i_core_end_op(core_end)
   );

   // Core model: all-ones, or a tag plus the address being read.
   assign core_dout = core_allf ? {64{1'b1}}
                                : {32'hC0DE_0000, core_add[31:0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && core_ctl[3:0] != 4'd0) begin
         n_cmp++;
         assert (exp_ops.size() != 0) else begin
            n_err++;
            $error("FAIL op_unexpected observed=%h expected=none",
                   core_ctl);
         end
         if (exp_ops.size() != 0) begin
            op_t e;
            e = exp_ops.pop_front();
            chk("op_code", 64'(core_ctl[3:0]), 64'(e.op));
            chk("op_add", core_add, e.add);
            chk("op_mode", 64'(core_ctl[31:4]), 64'(e.md));
            if (e.chk_data) chk("op_data", core_din, e.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         res_seen++;
         n_cmp++;
         assert (exp_res.size() != 0) else begin
            n_err++;
            $error("FAIL res_unexpected observed=%h expected=none", m_data);
         end
         if (exp_res.size() != 0) begin
            logic [64:0] r;
            r = exp_res.pop_front();
            chk("res_data", m_data, r[63:0]);
            chk("res_last", 64'(m_last), 64'(r[64]));
         end
      end
   end

   always @(negedge clk) if (rst_n && done) done_cnt++;

   task automatic push_op(input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] d, input logic cd);
      op_t e;
      e.op = op; e.add = a; e.data = d; e.chk_data = cd; e.md = mode;
      exp_ops.push_back(e);
   endtask

   task automatic push_load_start();
      for (int i = 0; i < 4; i++) push_op(4'd1, 64'(i), words[i], 1'b1);
      push_op(4'd2, 64'd0, 64'd0, 1'b0);
   endtask

   task automatic push_reads(input int n, input logic allf);
      for (int i = 0; i < n; i++) begin
         logic [63:0] w;
         push_op(4'd3, 64'(i), 64'd0, 1'b0);
         w = allf ? {64{1'b1}} : {32'hC0DE_0000, 32'(i)};
         exp_res.push_back({(i == n - 1), w});
      end
   endtask

   task automatic do_start(input logic [27:0] md);
      mode = md;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] d);
      logic ok;
      logic r;
      ok = 1'b0;
      s_data = d;
      s_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         r = s_ready;
         tick();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_accept", 64'(ok), 64'd1);
   endtask

   task automatic run_to_idle(input int exp_done);
      int d0;
      logic ok;
      d0 = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_reached", 64'(ok), 64'd1);
      chk("done_pulses", 64'(done_cnt - d0), 64'(exp_done));
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, 64'({busy, done, error, s_ready, m_valid, m_last}), 64'd0);
      chk(tag, 64'(core_ctl), 64'd0);
      chk(tag, core_add | core_din | m_data, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      int d0;
      logic ok;
      rst_n = 1'b1; start = 1'b0; mode = '0; abort = 1'b0;
      s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
      core_end = 1'b1; core_allf = 1'b1;
      #1 rst_n = 1'b0;
      tick(); tick();
      chk_all_zero("reset_state");
      rst_n = 1'b1;
      tick();

      // 1: all-ones core, back-to-back words
      words = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
      mode = 28'h1234567;
      push_load_start();
      push_reads(4, 1'b1);
      do_start(28'h1234567);
      for (int i = 0; i < 4; i++) send_word(words[i]);
      s_valid = 1'b0;
      run_to_idle(1);
      chk("t1_error", 64'(error), 64'd0);
      chk("t1_ops_left", 64'(exp_ops.size()), 64'd0);
      chk("t1_res_left", 64'(exp_res.size()), 64'd0);

      // 2+4: toggling valid, then stall on result word 2
      core_allf = 1'b0;
      words = '{64'h11, 64'h22, 64'h33, 64'h44};
      mode = 28'hABCDEF1;
      push_load_start();
      push_reads(4, 1'b0);
      do_start(28'hABCDEF1);
      for (int i = 0; i < 4; i++) begin
         send_word(words[i]);
         s_valid = 1'b0;
         tick();
      end
      r0 = res_seen;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (res_seen - r0 >= 2) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("t4_two_words", 64'(ok), 64'd1);
      m_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("t4_word2_valid", 64'(ok), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t4_stall_valid", 64'(m_valid), 64'd1);
         chk("t4_stall_data", m_data, {32'hC0DE_0000, 32'd2});
         chk("t4_stall_op", 64'(core_ctl[3:0]), 64'd0);
         tick();
      end
      m_ready = 1'b1;
      run_to_idle(1);
      chk("t4_ops_left", 64'(exp_ops.size()), 64'd0);
      chk("t4_res_left", 64'(exp_res.size()), 64'd0);

      // 3: end_op stuck low, timeout of 8 wait cycles
      core_end = 1'b0;
      words = '{64'h5, 64'h6, 64'h7, 64'h8};
      mode = 28'h0000042;
      push_load_start();
      do_start(28'h0000042);
      for (int i = 0; i < 4; i++) send_word(words[i]);
      s_valid = 1'b0;
      d0 = done_cnt;
      repeat (8) tick();
      chk("t3_no_err_yet", 64'(error), 64'd0);
      tick();
      chk("t3_error_set", 64'(error), 64'd1);
      chk("t3_done_pulse", 64'(done), 64'd1);
      tick();
      chk("t3_done_clear", 64'(done), 64'd0);
      chk("t3_idle", 64'(busy), 64'd0);
      chk("t3_error_sticky", 64'(error), 64'd1);
      chk("t3_done_count", 64'(done_cnt - d0), 64'd1);
      chk("t3_ops_left", 64'(exp_ops.size()), 64'd0);

      // new start clears error; reset after two words
      mode = 28'h0000077;
      push_op(4'd1, 64'd0, 64'hB0, 1'b1);
      push_op(4'd1, 64'd1, 64'hB1, 1'b1);
      do_start(28'h0000077);
      chk("t3_error_cleared", 64'(error), 64'd0);
      send_word(64'hB0);
      send_word(64'hB1);
      s_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      chk_all_zero("reset_mid_load");
      tick(); tick();
      chk_all_zero("reset_held");
      rst_n = 1'b1;
      tick();
      chk("rst_ops_left", 64'(exp_ops.size()), 64'd0);

      // fresh start after reset: adds restart at 0
      core_end = 1'b1;
      words = '{64'hC0, 64'hC1, 64'hC2, 64'hC3};
      mode = 28'h0BEEF00;
      push_load_start();
      push_reads(4, 1'b0);
      do_start(28'h0BEEF00);
      for (int i = 0; i < 4; i++) send_word(words[i]);
      s_valid = 1'b0;
      run_to_idle(1);
      chk("t6_ops_left", 64'(exp_ops.size()), 64'd0);
      chk("t6_res_left", 64'(exp_res.size()), 64'd0);

      // 5a: abort in WAIT
      core_end = 1'b0;
      words = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
      mode = 28'h0000011;
      push_load_start();
      do_start(28'h0000011);
      for (int i = 0; i < 4; i++) send_word(words[i]);
      s_valid = 1'b0;
      tick(); tick(); tick();
      d0 = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5a_busy", 64'(busy), 64'd0);
      chk("t5a_valid", 64'(m_valid), 64'd0);
      chk("t5a_op", 64'(core_ctl[3:0]), 64'd0);
      repeat (10) tick();
      chk("t5a_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t5a_error", 64'(error), 64'd0);
      chk("t5a_ops_left", 64'(exp_ops.size()), 64'd0);

      // 5b: abort in RD_OUT
      core_end = 1'b1;
      m_ready = 1'b0;
      words = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
      mode = 28'h0000022;
      push_load_start();
      push_op(4'd3, 64'd0, 64'd0, 1'b0);
      do_start(28'h0000022);
      for (int i = 0; i < 4; i++) send_word(words[i]);
      s_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("t5b_valid_seen", 64'(ok), 64'd1);
      d0 = done_cnt;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5b_busy", 64'(busy), 64'd0);
      chk("t5b_valid", 64'(m_valid), 64'd0);
      chk("t5b_last", 64'(m_last), 64'd0);
      m_ready = 1'b1;
      repeat (5) tick();
      chk("t5b_no_done", 64'(done_cnt - d0), 64'd0);
      chk("t5b_ops_left", 64'(exp_ops.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
